// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-sequencing state encoding, the default address map
// and a helper for sizing slave-index vectors.
package apb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StErr,
        StResp
    } apb_state_e;

    localparam int unsigned APB_BASE_ADDR = 32'h0000_0080;
    localparam int unsigned APB_SPAN_BITS = 4;

    // Width of a slave index; never zero so a single-slave build still has a vector.
    function automatic int unsigned apb_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decoder.
// Maps an unfiltered master address onto a window of SLAVE_PORTS equal slave regions of
// 2**SPAN_BITS bytes starting at BASE_ADDR.
// Ports:
//   addr    in   BUS_WIDTH        master address
//   hit     out  1                address falls inside a mapped slave window
//   idx     out  idx width        slave number (meaningful only when hit)
//   offset  out  SPAN_BITS        offset inside the slave window
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 16,
    parameter int unsigned SLAVE_PORTS = 4,
    parameter int unsigned BASE_ADDR   = APB_BASE_ADDR,
    parameter int unsigned SPAN_BITS   = APB_SPAN_BITS
) (
    input  logic [BUS_WIDTH-1:0]                  addr,
    output logic                                  hit,
    output logic [apb_idx_width(SLAVE_PORTS)-1:0] idx,
    output logic [SPAN_BITS-1:0]                  offset
);

    localparam int unsigned IdxW = apb_idx_width(SLAVE_PORTS);
    localparam logic [BUS_WIDTH-1:0] Base  = BUS_WIDTH'(BASE_ADDR);
    localparam logic [BUS_WIDTH-1:0] Ports = BUS_WIDTH'(SLAVE_PORTS);

    logic [BUS_WIDTH-1:0] win;

    always_comb begin
        // Addresses below the base wrap to large values here; the >= term rejects them.
        win    = (addr - Base) >> SPAN_BITS;
        hit    = (addr >= Base) && (win < Ports);
        idx    = win[IdxW-1:0];
        offset = addr[SPAN_BITS-1:0];
    end

endmodule

// File: rtl/apb_intercon_mux.sv
// APB interconnect between one master and SLAVE_PORTS slaves.
// Decodes the master address, re-bases it to a per-slave offset, runs the SETUP/ACCESS
// sequence on the selected slave and returns registered read data and error. Unmapped
// addresses and slaves that stall past TIMEOUT access cycles complete with an error.
// Ports:
//   S_PCLK, S_PRESETn          clock (rising edge), asynchronous active-low reset
//   S_PADDR/PWRITE/PSELx/PENABLE/PWDATA   master request
//   S_PRDATA/PREADY/PSLVERR    master response; PREADY is a one-cycle pulse
//   M_PADDR/PWRITE/PENABLE/PWDATA         shared slave request (offset address)
//   M_PSELx                    one-hot slave select
//   M_PRDATA/PREADY/PSLVERR    per-slave responses, slave i at slice i
module apb_intercon_mux
    import apb_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 16,
    parameter int unsigned SLAVE_PORTS = 4,
    parameter int unsigned BASE_ADDR   = APB_BASE_ADDR,
    parameter int unsigned SPAN_BITS   = APB_SPAN_BITS,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic                             S_PCLK,
    input  logic                             S_PRESETn,
    input  logic [BUS_WIDTH-1:0]             S_PADDR,
    input  logic                             S_PWRITE,
    input  logic                             S_PSELx,
    input  logic                             S_PENABLE,
    input  logic [BUS_WIDTH-1:0]             S_PWDATA,
    output logic [BUS_WIDTH-1:0]             S_PRDATA,
    output logic                             S_PREADY,
    output logic                             S_PSLVERR,
    output logic [BUS_WIDTH-1:0]             M_PADDR,
    output logic                             M_PWRITE,
    output logic                             M_PENABLE,
    output logic [SLAVE_PORTS-1:0]           M_PSELx,
    output logic [BUS_WIDTH-1:0]             M_PWDATA,
    input  logic [SLAVE_PORTS*BUS_WIDTH-1:0] M_PRDATA,
    input  logic [SLAVE_PORTS-1:0]           M_PREADY,
    input  logic [SLAVE_PORTS-1:0]           M_PSLVERR
);

    localparam int unsigned IdxW = apb_idx_width(SLAVE_PORTS);
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e state_q, state_d;

    logic [IdxW-1:0]      idx_q, idx_d;
    logic [SPAN_BITS-1:0] offset_q, offset_d;
    logic                 write_q, write_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 dec_hit;
    logic [IdxW-1:0]      dec_idx;
    logic [SPAN_BITS-1:0] dec_offset;

    logic                 start;
    logic                 timeout_hit;
    logic                 sel_ready;
    logic                 sel_err;
    logic [BUS_WIDTH-1:0] sel_rdata;

    apb_addr_decode #(
        .BUS_WIDTH   (BUS_WIDTH),
        .SLAVE_PORTS (SLAVE_PORTS),
        .BASE_ADDR   (BASE_ADDR),
        .SPAN_BITS   (SPAN_BITS)
    ) u_decode (
        .addr   (S_PADDR),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_offset)
    );

    // Response path of the latched slave only.
    always_comb begin
        sel_ready = M_PREADY[idx_q];
        sel_err   = M_PSLVERR[idx_q];
        sel_rdata = M_PRDATA[int'(idx_q) * BUS_WIDTH +: BUS_WIDTH];
    end

    always_comb begin
        // PENABLE high in IDLE is the tail of the previous transfer, not a new SETUP.
        start       = S_PSELx && !S_PENABLE;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

        state_d  = state_q;
        idx_d    = idx_q;
        offset_d = offset_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        cnt_d    = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d    = dec_idx;
                    offset_d = dec_offset;
                    write_d  = S_PWRITE;
                    wdata_d  = S_PWDATA;
                    state_d  = dec_hit ? StSetup : StErr;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                // Saturate rather than wrap so a disabled timeout never fires spuriously.
                cnt_d = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                if (sel_ready) begin
                    rdata_d = write_q ? '0 : sel_rdata;
                    err_d   = sel_err;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StErr: begin
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge S_PCLK or negedge S_PRESETn) begin
        if (!S_PRESETn) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            offset_q <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            offset_q <= offset_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        M_PSELx = '0;
        if (state_q == StSetup || state_q == StAccess) begin
            M_PSELx[idx_q] = 1'b1;
        end
        M_PENABLE = (state_q == StAccess);
        M_PADDR   = BUS_WIDTH'(offset_q);
        M_PWRITE  = write_q;
        M_PWDATA  = wdata_q;
        S_PREADY  = (state_q == StResp);
        S_PRDATA  = rdata_q;
        S_PSLVERR = err_q;
    end

endmodule

// File: tb/tb_apb_intercon_mux.sv
// Self-checking bench for apb_intercon_mux: directed and random APB transfers, expected
// responses from an arithmetic address-map model pushed to a scoreboard queue.
module tb_apb_intercon_mux;

    localparam int NS   = 4;
    localparam int TO   = 15;
    localparam int BASE = 128;
    localparam int SPAN = 16;

    typedef struct {
        logic        mapped;
        int          slave;
        logic [15:0] off;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [15:0] pwdata = '0;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [15:0] m_paddr;
    logic        m_pwrite;
    logic        m_penable;
    logic [3:0]  m_psel;
    logic [15:0] m_pwdata;
    logic [63:0] m_prdata;
    logic [3:0]  m_pready;
    logic [3:0]  m_pslverr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_n = 0;
    bit done  = 0;

    int          cfg_w     = 0;
    logic        cfg_never = 1'b0;
    logic        cfg_err   = 1'b0;
    logic [15:0] cfg_rdata = '0;
    logic [63:0] noise_data = '0;
    logic [3:0]  noise_rdy  = '0;
    logic [3:0]  noise_err  = '0;

    exp_t exp_q[$];

    apb_intercon_mux #(
        .BUS_WIDTH   (16),
        .SLAVE_PORTS (NS),
        .BASE_ADDR   (BASE),
        .SPAN_BITS   (4),
        .TIMEOUT     (TO)
    ) dut (
        .S_PCLK    (clk),
        .S_PRESETn (rst_n),
        .S_PADDR   (paddr),
        .S_PWRITE  (pwrite),
        .S_PSELx   (psel),
        .S_PENABLE (penable),
        .S_PWDATA  (pwdata),
        .S_PRDATA  (prdata),
        .S_PREADY  (pready),
        .S_PSLVERR (pslverr),
        .M_PADDR   (m_paddr),
        .M_PWRITE  (m_pwrite),
        .M_PENABLE (m_penable),
        .M_PSELx   (m_psel),
        .M_PWDATA  (m_pwdata),
        .M_PRDATA  (m_prdata),
        .M_PREADY  (m_pready),
        .M_PSLVERR (m_pslverr)
    );

    always #5 clk = ~clk;

    // Cycle counter, slave wait-state counter and garbage on unselected slaves.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        acc_n      <= (m_penable && m_psel != 0) ? acc_n + 1 : 0;
        noise_data <= {$urandom, $urandom};
        noise_rdy  <= 4'($urandom);
        noise_err  <= 4'($urandom);
    end

    // Selected slave answers after cfg_w access cycles; others drive noise.
    always_comb begin
        m_prdata  = noise_data;
        m_pready  = noise_rdy;
        m_pslverr = noise_err;
        for (int s = 0; s < NS; s++) begin
            if (m_psel[s]) begin
                m_pready[s]          = m_penable && !cfg_never && (acc_n == cfg_w);
                m_prdata[s*16 +: 16] = cfg_rdata;
                m_pslverr[s]         = cfg_err;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_pready"}, 32'(pready), 0);
        chk({tag, "_prdata"}, 32'(prdata), 0);
        chk({tag, "_pslverr"}, 32'(pslverr), 0);
        chk({tag, "_m_psel"}, 32'(m_psel), 0);
        chk({tag, "_m_penable"}, 32'(m_penable), 0);
        chk({tag, "_m_paddr"}, 32'(m_paddr), 0);
        chk({tag, "_m_pwrite"}, 32'(m_pwrite), 0);
        chk({tag, "_m_pwdata"}, 32'(m_pwdata), 0);
    endtask

    // Address map: 4 windows of 16 bytes from 0x80; slave stalls past TO cycles time out.
    function automatic exp_t model(input logic [15:0] addr, input logic wr,
                                   input logic [15:0] wd, input int w, input logic never,
                                   input logic [15:0] rd, input logic se);
        exp_t e;
        int unsigned a;
        a       = addr;
        e.wr    = wr;
        e.wdata = wd;
        e.t0    = 0;
        if (a >= BASE && (a - BASE) / SPAN < NS) begin
            e.mapped = 1'b1;
            e.slave  = int'((a - BASE) / SPAN);
            e.off    = 16'(a % SPAN);
            if (never || w > TO) begin
                e.rdata = '0;
                e.err   = 1'b1;
                e.lat   = 3 + TO;
            end else begin
                e.rdata = wr ? 16'h0 : rd;
                e.err   = se;
                e.lat   = 3 + w;
            end
        end else begin
            e.mapped = 1'b0;
            e.slave  = 0;
            e.off    = '0;
            e.rdata  = '0;
            e.err    = 1'b1;
            e.lat    = 2;
        end
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the first IDLE cycle (or one later on hold).
    task automatic xfer(input logic [15:0] addr, input logic wr, input logic [15:0] wd,
                        input int w, input logic never, input logic [15:0] rd,
                        input logic se, input logic hold);
        exp_t e;
        bit   seen;
        seen      = 0;
        cfg_w     = w;
        cfg_never = never;
        cfg_rdata = rd;
        cfg_err   = se;
        e         = model(addr, wr, wd, w, never, rd, se);
        e.t0      = cyc;
        exp_q.push_back(e);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = pready;
        end
        if (!seen) begin
            chk("ready_timeout", 32'(pready), 1);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        // Master lingers in ACCESS-like state for a cycle; must not retrigger.
        if (hold) begin
            @(posedge clk);
            #1;
        end
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic reset_mid_access();
        exp_t e;
        cfg_never = 1'b1;
        cfg_w     = 0;
        cfg_rdata = 16'h5555;
        cfg_err   = 1'b0;
        e         = model(16'h00A7, 1'b0, 16'h0, 0, 1'b1, 16'h5555, 1'b0);
        e.t0      = cyc;
        e.lat     = -1; // any acknowledgement of this dropped transfer is an error
        exp_q.push_back(e);
        paddr   = 16'h00A7;
        pwrite  = 1'b0;
        pwdata  = 16'h0;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("mid_reset");
        psel    = 1'b0;
        penable = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
    endtask

    task automatic run_random(input int n);
        logic [15:0] a;
        int          r;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6) a = 16'(BASE + $urandom_range(0, 63));
            else if (r < 8) a = 16'($urandom_range(0, 127));
            else a = 16'($urandom_range(192, 65535));
            xfer(a, 1'($urandom), 16'($urandom), $urandom_range(0, 4),
                 ($urandom_range(0, 9) == 0), 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        fork
            begin
                xfer(16'h0093, 1'b0, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
                xfer(16'h00A5, 1'b1, 16'h1234, 2, 1'b0, 16'hDEAD, 1'b0, 1'b0);
                xfer(16'h0040, 1'b0, 16'h0000, 0, 1'b0, 16'h1111, 1'b0, 1'b0);
                xfer(16'h00C0, 1'b0, 16'h0000, 0, 1'b0, 16'h1111, 1'b0, 1'b0);
                xfer(16'h007F, 1'b1, 16'hAAAA, 0, 1'b0, 16'h1111, 1'b0, 1'b0);
                xfer(16'h0080, 1'b0, 16'h0000, 1, 1'b0, 16'h0F0F, 1'b0, 1'b0);
                xfer(16'h00BF, 1'b0, 16'h0000, 0, 1'b0, 16'hF00D, 1'b0, 1'b0);
                xfer(16'h00B0, 1'b0, 16'h0000, 0, 1'b1, 16'h2222, 1'b0, 1'b0);
                xfer(16'h0081, 1'b0, 16'h0000, 0, 1'b0, 16'h3333, 1'b0, 1'b1);
                xfer(16'h0085, 1'b0, 16'h0000, 1, 1'b0, 16'hCAFE, 1'b1, 1'b0);
                xfer(16'h0096, 1'b0, 16'h0000, 15, 1'b0, 16'h4444, 1'b0, 1'b0);
                xfer(16'h0096, 1'b0, 16'h0000, 16, 1'b0, 16'h4444, 1'b0, 1'b0);
                xfer(16'h0093, 1'b0, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
                reset_mid_access();
                xfer(16'h0093, 1'b0, 16'h0000, 0, 1'b0, 16'h7777, 1'b0, 1'b0);
                run_random(150);
                idle(5);
                chk("queue_empty", 32'(exp_q.size()), 0);
                done = 1;
            end
            begin
                exp_t e;
                while (!done) begin
                    @(negedge clk);
                    if (pready) begin
                        if (exp_q.size() == 0) begin
                            chk("spurious_ready", 32'(pready), 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("s_prdata", 32'(prdata), 32'(e.rdata));
                            chk("s_pslverr", 32'(pslverr), 32'(e.err));
                            chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                        end
                    end
                    if (m_psel != 0) begin
                        if (exp_q.size() == 0 || !exp_q[0].mapped) begin
                            chk("sel_unexpected", 32'(m_psel), 0);
                        end else begin
                            e = exp_q[0];
                            chk("m_psel", 32'(m_psel), 32'(1) << e.slave);
                            chk("m_paddr", 32'(m_paddr), 32'(e.off));
                            chk("m_pwrite", 32'(m_pwrite), 32'(e.wr));
                            chk("m_pwdata", 32'(m_pwdata), 32'(e.wdata));
                        end
                    end
                end
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
